// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Owns the PC and issues requests to a variable-latency instruction memory.
// A fetched word goes straight into IF/ID unless decode is stalled. In that
// case it is parked in a one-entry skid buffer and no further request is
// issued until the stall clears. Redirects take priority over stall. They
// flush IF/ID to a bubble and drop the skid buffer. If the redirect arrives
// while a request is still waiting on memory, that request's response is
// squashed, and the new target is fetched once the response has come back.
//
// Optional feature: define FETCH_PERF_EN to add three 16-bit saturating
// performance counters (perf_fetched, perf_stall_cycles, perf_flushes).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     hazard-detector stall (hold PC and IF/ID)
//   branchTaken, pcSel        redirect request and target select
//                             (00 seq, 01 branch, 10 jump, 11 return)
//   branchTarget, jumpTarget, retTarget
//                             redirect targets
//   imem_req, imem_addr       fetch request and address
//   imem_rdata, imem_ready    response word and completion strobe
//   IF_ID_Inst, IF_ID_PC      instruction and its PC presented to decode
//   IF_ID_valid               IF_ID_Inst is a real fetched instruction
//   perf_*                    (FETCH_PERF_EN only) event counters
module fetch_stage #(
    parameter int unsigned         PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [15:0]         NOP_INST = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branchTaken,
    input  logic [1:0]          pcSel,
    input  logic [PC_WIDTH-1:0] branchTarget,
    input  logic [PC_WIDTH-1:0] jumpTarget,
    input  logic [PC_WIDTH-1:0] retTarget,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    input  logic                imem_ready,
    output logic [15:0]         IF_ID_Inst,
    output logic [PC_WIDTH-1:0] IF_ID_PC,
    output logic                IF_ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_stall_cycles,
    output logic [15:0]         perf_flushes
`endif
);

    typedef enum logic [1:0] {StBoot, StReq, StHold} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                squash_q, squash_d;
    logic [PC_WIDTH-1:0] squash_addr_q, squash_addr_d;
    logic [15:0]         skid_inst_q, skid_inst_d;
    logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [15:0]         inst_q, inst_d;
    logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic                valid_q, valid_d;

    logic                fetching;
    logic                accept;
    logic                redirect;
    logic [PC_WIDTH-1:0] target;

    assign fetching = (state_q == StReq);
    assign accept   = fetching && imem_ready;
    // pcSel=00 with branchTaken is not a redirect.
    assign redirect = branchTaken && (pcSel != 2'b00);

    always_comb begin
        case (pcSel)
            2'b01:   target = branchTarget;
            2'b10:   target = jumpTarget;
            2'b11:   target = retTarget;
            default: target = pc_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            squash_q      <= 1'b0;
            squash_addr_q <= RESET_PC;
            skid_inst_q   <= NOP_INST;
            skid_pc_q     <= '0;
            inst_q        <= NOP_INST;
            ifid_pc_q     <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            squash_addr_q <= squash_addr_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            inst_q        <= inst_d;
            ifid_pc_q     <= ifid_pc_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_d      = squash_q;
        squash_addr_d = squash_addr_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;
        inst_d        = inst_q;
        ifid_pc_d     = ifid_pc_q;
        valid_d       = valid_q;

        if (redirect) begin
            state_d = StReq;
            pc_d    = target;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            if (fetching && !imem_ready) begin
                // Keep the in-flight address on the bus until memory answers.
                squash_d = 1'b1;
                if (!squash_q) begin
                    squash_addr_d = pc_q;
                end
            end else begin
                squash_d = 1'b0;
            end
        end else begin
            case (state_q)
                StBoot: state_d = StReq;
                StReq: begin
                    if (accept && !squash_q) begin
                        pc_d = pc_q + PC_WIDTH'(1);
                        if (stall) begin
                            skid_inst_d = imem_rdata;
                            skid_pc_d   = pc_q;
                            state_d     = StHold;
                        end else begin
                            inst_d    = imem_rdata;
                            ifid_pc_d = pc_q;
                            valid_d   = 1'b1;
                        end
                    end else begin
                        if (accept) begin
                            squash_d = 1'b0;
                        end
                        if (!stall) begin
                            inst_d  = NOP_INST;
                            valid_d = 1'b0;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        inst_d    = skid_inst_q;
                        ifid_pc_d = skid_pc_q;
                        valid_d   = 1'b1;
                        state_d   = StReq;
                    end
                end
                default: state_d = StBoot;
            endcase
        end
    end

    // Outputs
    always_comb begin
        imem_req    = fetching;
        imem_addr   = squash_q ? squash_addr_q : pc_q;
        IF_ID_Inst  = inst_q;
        IF_ID_PC    = ifid_pc_q;
        IF_ID_valid = valid_q;
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            // Count only responses that are kept, not squashed or flushed ones.
            if (accept && !squash_q && !redirect && perf_fetched != 16'hFFFF) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (stall && perf_stall_cycles != 16'hFFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 16'd1;
            end
            if (redirect && perf_flushes != 16'hFFFF) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: bench for fetch_stage. A memory responder with fixed or
// random wait states drives the DUT. A behavioural model of the fetch
// stream is checked against the DUT on every cycle. Directed sequences also
// pin the expected values with literals.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branchTaken, imem_ready;
    logic [1:0]  pcSel;
    logic [15:0] branchTarget, jumpTarget, retTarget, imem_rdata;
    logic        imem_req, IF_ID_valid;
    logic [15:0] imem_addr, IF_ID_Inst, IF_ID_PC;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_stall_cycles, perf_flushes;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .pcSel        (pcSel),
        .branchTarget (branchTarget),
        .jumpTarget   (jumpTarget),
        .retTarget    (retTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .IF_ID_Inst   (IF_ID_Inst),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_valid  (IF_ID_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the stage
    logic [15:0] m_pc, m_inst, m_ipc, m_skid_inst, m_skid_pc, m_sq_addr;
    bit          m_valid, m_boot, m_hold, m_sq;
    int          m_pf, m_ps, m_pfl;

    // Memory responder state
    int          waits = 0;
    bit          rand_waits = 1'b0;
    bit          pend = 1'b0;
    logic [15:0] pend_addr = '0;
    int          wcnt = 0;
    int          cur_waits = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA000;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check16("imem_req", 16'(imem_req), 16'(!m_boot && !m_hold));
        check16("imem_addr", imem_addr, m_sq ? m_sq_addr : m_pc);
        check16("IF_ID_Inst", IF_ID_Inst, m_inst);
        check16("IF_ID_PC", IF_ID_PC, m_ipc);
        check16("IF_ID_valid", 16'(IF_ID_valid), 16'(m_valid));
`ifdef FETCH_PERF_EN
        check16("perf_fetched", perf_fetched, 16'(m_pf));
        check16("perf_stall_cycles", perf_stall_cycles, 16'(m_ps));
        check16("perf_flushes", perf_flushes, 16'(m_pfl));
`endif
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        bit          m_req, acc, redir;
        logic [15:0] tgt;
        m_req = !m_boot && !m_hold;
        acc   = m_req && imem_ready;
        redir = branchTaken && (pcSel != 2'b00);
        tgt   = (pcSel == 2'b01) ? branchTarget :
                (pcSel == 2'b10) ? jumpTarget : retTarget;
        if (rst) begin
            m_pc = 16'h0000; m_inst = 16'h0000; m_ipc = 16'h0000; m_valid = 1'b0;
            m_boot = 1'b1; m_hold = 1'b0; m_sq = 1'b0; m_sq_addr = 16'h0000;
            m_skid_inst = 16'h0000; m_skid_pc = 16'h0000;
            m_pf = 0; m_ps = 0; m_pfl = 0;
        end else begin
            if (stall) m_ps = sat_inc(m_ps);
            if (redir) begin
                m_pfl = sat_inc(m_pfl);
                m_inst = 16'h0000; m_valid = 1'b0; m_hold = 1'b0; m_boot = 1'b0;
                if (m_req && !imem_ready) begin
                    if (!m_sq) m_sq_addr = m_pc;
                    m_sq = 1'b1;
                end else begin
                    m_sq = 1'b0;
                end
                m_pc = tgt;
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_hold) begin
                if (!stall) begin
                    m_inst = m_skid_inst; m_ipc = m_skid_pc; m_valid = 1'b1; m_hold = 1'b0;
                end
            end else if (acc && !m_sq) begin
                m_pf = sat_inc(m_pf);
                if (!stall) begin
                    m_inst = imem_rdata; m_ipc = m_pc; m_valid = 1'b1;
                end else begin
                    m_skid_inst = imem_rdata; m_skid_pc = m_pc; m_hold = 1'b1;
                end
                m_pc = m_pc + 16'd1;
            end else begin
                if (acc) m_sq = 1'b0;
                if (!stall) begin
                    m_inst = 16'h0000; m_valid = 1'b0;
                end
            end
        end
    endtask

    // Drive the memory response, step the model, cross the edge, compare.
    task automatic tick();
        if (imem_req === 1'b1) begin
            if (pend && imem_addr == pend_addr) begin
                wcnt++;
            end else begin
                wcnt = 0;
                cur_waits = rand_waits ? int'($urandom_range(0, 3)) : waits;
            end
            imem_ready = (wcnt >= cur_waits);
            imem_rdata = mem_word(imem_addr);
            pend       = !imem_ready;
            pend_addr  = imem_addr;
        end else begin
            // Stray ready with junk data while idle must be ignored.
            imem_ready = rand_waits ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 16'($urandom);
            pend       = 1'b0;
        end
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; pcSel = 2'b00;
        branchTarget = '0; jumpTarget = '0; retTarget = '0;
        imem_ready = 1'b0; imem_rdata = '0;

        // Reset values
        tick();
        tick();
        check16("rst_req", 16'(imem_req), 16'h0000);
        check16("rst_addr", imem_addr, 16'h0000);
        check16("rst_inst", IF_ID_Inst, 16'h0000);
        check16("rst_pc", IF_ID_PC, 16'h0000);
        check16("rst_valid", 16'(IF_ID_valid), 16'h0000);

        // Zero-wait streaming
        rst = 1'b0;
        tick();
        check16("boot_req", 16'(imem_req), 16'h0001);
        check16("boot_valid", 16'(IF_ID_valid), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check16("zw_pc", IF_ID_PC, 16'(i));
            check16("zw_inst", IF_ID_Inst, 16'hA000 | 16'(i));
            check16("zw_valid", 16'(IF_ID_valid), 16'h0001);
        end

        // Two wait states: one fetch every three cycles
        waits = 2;
        for (int f = 4; f < 6; f++) begin
            for (int k = 0; k < 2; k++) begin
                tick();
                check16("ws_bubble_valid", 16'(IF_ID_valid), 16'h0000);
                check16("ws_bubble_inst", IF_ID_Inst, 16'h0000);
                check16("ws_addr_stable", imem_addr, 16'(f));
            end
            tick();
            check16("ws_pc", IF_ID_PC, 16'(f));
            check16("ws_valid", 16'(IF_ID_valid), 16'h0001);
        end

        // Stall for three cycles while PC 5 is being fetched
        waits = 0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check16("st_addr", imem_addr, 16'h0005);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check16("st_hold_pc", IF_ID_PC, 16'h0004);
            check16("st_hold_req", 16'(imem_req), 16'h0000);
        end
        stall = 1'b0;
        tick();
        check16("st_pc5", IF_ID_PC, 16'h0005);
        check16("st_inst5", IF_ID_Inst, 16'hA005);
        tick();
        check16("st_pc6", IF_ID_PC, 16'h0006);

        // Branch while a two-wait fetch of PC 8 is outstanding
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        waits = 2;
        tick();
        check16("br_addr8", imem_addr, 16'h0008);
        branchTaken = 1'b1; pcSel = 2'b01; branchTarget = 16'h0040;
        tick();
        check16("br_squash_addr", imem_addr, 16'h0008);
        check16("br_flush_valid", 16'(IF_ID_valid), 16'h0000);
        branchTaken = 1'b0; pcSel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check16("br_tgt_addr", imem_addr, 16'h0040);
            check16("br_no_valid", 16'(IF_ID_valid), 16'h0000);
        end
        tick();
        check16("br_pc", IF_ID_PC, 16'h0040);
        check16("br_inst", IF_ID_Inst, 16'hA040);
        check16("br_valid", 16'(IF_ID_valid), 16'h0001);

        // Jump and return with stall in the same cycle, then pcSel=00
        waits = 0;
        branchTaken = 1'b1; pcSel = 2'b10; jumpTarget = 16'h1234; stall = 1'b1;
        tick();
        check16("jmp_inst", IF_ID_Inst, 16'h0000);
        check16("jmp_valid", 16'(IF_ID_valid), 16'h0000);
        check16("jmp_addr", imem_addr, 16'h1234);
        branchTaken = 1'b0; stall = 1'b0;
        tick();
        check16("jmp_pc", IF_ID_PC, 16'h1234);
        branchTaken = 1'b1; pcSel = 2'b11; retTarget = 16'h0777; stall = 1'b1;
        tick();
        check16("ret_valid", 16'(IF_ID_valid), 16'h0000);
        check16("ret_addr", imem_addr, 16'h0777);
        pcSel = 2'b00; stall = 1'b0;
        tick();
        check16("seq_pc", IF_ID_PC, 16'h0777);
        check16("seq_addr", imem_addr, 16'h0778);
        branchTaken = 1'b0;
        tick();
        check16("seq_pc2", IF_ID_PC, 16'h0778);

        // PC wrap
        branchTaken = 1'b1; pcSel = 2'b10; jumpTarget = 16'hFFFF;
        tick();
        check16("wrap_addr_ffff", imem_addr, 16'hFFFF);
        branchTaken = 1'b0; pcSel = 2'b00;
        tick();
        check16("wrap_pc", IF_ID_PC, 16'hFFFF);
        check16("wrap_inst", IF_ID_Inst, 16'h5FFF);
        check16("wrap_addr_0", imem_addr, 16'h0000);

        // Randomized traffic against the model
        rand_waits = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            branchTaken  = ($urandom_range(0, 9) == 0);
            pcSel        = 2'($urandom_range(0, 3));
            branchTarget = 16'($urandom);
            jumpTarget   = 16'($urandom);
            retTarget    = 16'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode controller and hazard detector.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Presents IF_ID_Inst / IF_ID_PC to decode.
- Obeys `stall` from the hazard detector and redirects from the branch controller (branchTaken, pcSel).

Parameters:
- PC_WIDTH, 16, width of PC and memory address.
- RESET_PC, 16'h0000, PC fetched first after reset.
- NOP_INST, 16'h0000, bubble instruction (opcode 0000) inserted on flush/empty.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-detector stall; hold PC and IF/ID.
- branchTaken  in  1  redirect request from branch controller.
- pcSel  in  2  00 seq, 01 branch target, 10 jump target, 11 return target.
- branchTarget  in  PC_WIDTH  target for pcSel 01.
- jumpTarget  in  PC_WIDTH  target for pcSel 10.
- retTarget  in  PC_WIDTH  target for pcSel 11.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address.
- imem_rdata  in  16  instruction word, valid when imem_ready=1.
- imem_ready  in  1  completes the current request this cycle.
- IF_ID_Inst  out  16  instruction to decode.
- IF_ID_PC  out  PC_WIDTH  PC of IF_ID_Inst.
- IF_ID_valid  out  1  IF_ID_Inst is a real fetched instruction.

Behaviour:
- Reset values:
  - PC=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - IF_ID_Inst=NOP_INST, IF_ID_PC=0, IF_ID_valid=0.
  - state=BOOT, squash=0, skid empty.
- Reset mid-request abandons the request; a late imem_ready after reset is ignored until BOOT exits.
- FSM states:
  - BOOT: one cycle with imem_req=0, then go to REQ.
  - REQ: imem_req=1, imem_addr=PC.
  - HOLD: response captured in a 1-entry skid buffer while stalled; imem_req=0.
- Memory handshake:
  - A transfer completes on a cycle with imem_req=1 and imem_ready=1.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - Zero-wait memory (ready in the same cycle as req) sustains 1 instruction/cycle.
  - Latency: address presented in cycle N, ready in N, IF_ID_Inst valid from the edge ending N.
- REQ, response accepted, stall=0: load IF/ID {rdata, PC, valid=1}; PC<=PC+1 (wraps modulo 2^PC_WIDTH); stay in REQ.
- REQ, response accepted, stall=1: write the word to the skid buffer; PC<=PC+1; go to HOLD. IF/ID holds.
- HOLD, stall=0: move skid to IF/ID; go to REQ.
- REQ, no response, stall=0: IF/ID <= bubble {NOP_INST, valid=0}.
- REQ, no response, stall=1: IF/ID holds.
- Redirect (branchTaken=1 and pcSel!=00):
  - Has priority over stall.
  - IF/ID <= bubble, skid cleared, PC <= selected target.
  - If a request is outstanding and imem_ready=0, set squash=1 and keep imem_addr stable. The next accepted response is discarded, squash clears, then the target is requested.
  - If imem_ready=1 in the redirect cycle, the returned data is discarded and no squash is needed.
- branchTaken=1 with pcSel=00: no redirect; treat as branchTaken=0.
- Redirect in HOLD: skid dropped, go to REQ at the target.
- Redirect and stall together: redirect applies; IF/ID becomes the bubble.
- stall never modifies PC or issues a second request while the skid is full.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined, adds three outputs, each a 16-bit saturating counter cleared by rst:
  - perf_fetched: accepted, non-squashed responses.
  - perf_stall_cycles: cycles with stall=1.
  - perf_flushes: redirects taken.
- Counters stop at 16'hFFFF.
- Undefined: no ports, no counter logic; all other behaviour identical.

Test Plan:
- Reset release, zero-wait memory returning {inst=addr^16'hA000} -> IF_ID_PC 0,1,2,3 on consecutive cycles, IF_ID_Inst 16'hA000,16'hA001,…, IF_ID_valid=1 from the 3rd cycle after reset release.
- Memory with 2 wait states -> imem_addr stable for 3 cycles per fetch, one valid IF/ID every 3 cycles, bubbles (NOP, valid=0) between.
- stall=1 for 3 cycles while fetching PC 5 -> IF/ID holds PC 4, word 5 held in skid, imem_req=0 in HOLD; after stall drops, IF_ID_PC=5 then 6, no fetch lost or duplicated.
- branchTaken=1, pcSel=01, branchTarget=16'h0040 while a 2-wait fetch of PC 8 is outstanding -> PC 8 response discarded, next imem_addr=16'h0040, IF_ID_PC=16'h0040 valid with no instruction from PC 8/9 reaching decode.
- pcSel=10 and 11 with stall=1 in the same cycle -> redirect to jumpTarget/retTarget, IF_ID_Inst=16'h0000, IF_ID_valid=0; also pcSel=00 with branchTaken=1 -> sequential PC continues.
- PC=16'hFFFF fetched -> next imem_addr=16'h0000; with FETCH_PERF_EN, 70000 fetches -> perf_fetched=16'hFFFF.
